// File: rtl/keccak_pkg.sv
// Shared definitions for the Keccak state buffer: lane count, FSM state
// encoding, the FIPS 202 lane offset helper and the standard rate values.
package keccak_pkg;

  localparam int NUM_LANES = 25;

  // Rates (in lanes of a 64-bit Keccak-f[1600] state) of the standard functions
  localparam int RATE_SHA3_224 = 18;
  localparam int RATE_SHA3_256 = 17;
  localparam int RATE_SHA3_384 = 13;
  localparam int RATE_SHA3_512 = 9;
  localparam int RATE_SHAKE128 = 21;
  localparam int RATE_SHAKE256 = 17;

  typedef enum logic [1:0] {
    ABSORB  = 2'd0,
    PERMUTE = 2'd1,
    SQUEEZE = 2'd2
  } state_e;

  // Bit offset of lane (x,y) inside the flattened state vector
  function automatic int lane_base(input int x, input int y, input int w);
    return w * (x + 5 * y);
  endfunction

endpackage

// File: rtl/keccak_lane_bswap.sv
// Combinational byte-order reversal of one lane; used to present a
// big-endian byte interface on the absorb and squeeze ports.
module keccak_lane_bswap #(
  parameter int LANE_W = 64
) (
  input  logic [LANE_W-1:0] lane,
  output logic [LANE_W-1:0] swapped
);

  localparam int NBYTES = LANE_W / 8;

  // Byte b of the result is byte NBYTES-1-b of the input
  always_comb begin
    swapped = '0;
    for (int b = 0; b < NBYTES; b++) begin
      swapped[8*b +: 8] = lane[8*(NBYTES-1-b) +: 8];
    end
  end

endmodule

// File: rtl/keccak_state_buffer.sv
// Keccak state holder with streaming absorb/squeeze around an external
// Keccak-f permutation core. Optional macro KECCAK_LANE_BSWAP_EN byte-reverses
// absorbed and squeezed lanes (big-endian byte interface); the state vector
// exchanged with the permutation core is never swapped.
module keccak_state_buffer
  import keccak_pkg::*;
#(
  parameter int LANE_W     = 64,
  parameter int RATE_LANES = 17
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clear,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [LANE_W-1:0]             in_lane,
  input  logic                          in_last,
  output logic                          perm_start,
  input  logic                          perm_done,
  input  logic [NUM_LANES*LANE_W-1:0]   perm_state_i,
  output logic [NUM_LANES*LANE_W-1:0]   state_o,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [LANE_W-1:0]             out_lane
);

  localparam int STATE_W = NUM_LANES * LANE_W;
  localparam int IDX_W   = $clog2(RATE_LANES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATE_LANES - 1);

  if (!(LANE_W == 8 || LANE_W == 16 || LANE_W == 32 || LANE_W == 64)) begin : g_bad_lane_w
    $error("keccak_state_buffer: LANE_W must be 8, 16, 32 or 64");
  end
  if (RATE_LANES < 1 || RATE_LANES > 24) begin : g_bad_rate
    $error("keccak_state_buffer: RATE_LANES must be in 1..24");
  end

  state_e             fsm_q, fsm_d;
  logic [STATE_W-1:0] state_q;
  logic [IDX_W-1:0]   idx_q;
  logic               fin_q;
  logic               perm_start_q;
  logic [LANE_W-1:0]  absorb_lane;
  logic [LANE_W-1:0]  rate_lane;
  logic [LANE_W-1:0]  squeeze_lane;
  logic               in_fire, out_fire, block_end, perm_load;

`ifdef KECCAK_LANE_BSWAP_EN
  if (LANE_W % 8 != 0) begin : g_bad_bswap
    $error("keccak_state_buffer: byte swap needs LANE_W to be a multiple of 8");
  end
  keccak_lane_bswap #(.LANE_W(LANE_W)) u_in_bswap (
    .lane    (in_lane),
    .swapped (absorb_lane)
  );
  keccak_lane_bswap #(.LANE_W(LANE_W)) u_out_bswap (
    .lane    (rate_lane),
    .swapped (squeeze_lane)
  );
`else
  assign absorb_lane  = in_lane;
  assign squeeze_lane = rate_lane;
`endif

  // Handshakes and block-completion events decoded from the current state;
  // perm_done is not looked at while perm_start is still high
  always_comb begin
    in_ready  = (fsm_q == ABSORB);
    out_valid = (fsm_q == SQUEEZE);
    in_fire   = in_ready & in_valid;
    out_fire  = out_valid & out_ready;
    block_end = (in_fire | out_fire) & (idx_q == LAST_IDX);
    perm_load = (fsm_q == PERMUTE) & perm_done & ~perm_start_q;
    rate_lane = state_q[int'(idx_q)*LANE_W +: LANE_W];
    out_lane  = out_valid ? squeeze_lane : '0;
  end

  // Next-state logic; clear wins over every other event
  always_comb begin
    fsm_d = fsm_q;
    if (clear) begin
      fsm_d = ABSORB;
    end else begin
      case (fsm_q)
        ABSORB:  if (block_end) fsm_d = PERMUTE;
        PERMUTE: if (perm_load) fsm_d = fin_q ? SQUEEZE : ABSORB;
        SQUEEZE: if (block_end) fsm_d = PERMUTE;
        default: fsm_d = ABSORB;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) fsm_q <= ABSORB;
    else        fsm_q <= fsm_d;
  end

  // State, lane index, final-block flag and permutation start pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= '0;
      idx_q        <= '0;
      fin_q        <= 1'b0;
      perm_start_q <= 1'b0;
    end else if (clear) begin
      state_q      <= '0;
      idx_q        <= '0;
      fin_q        <= 1'b0;
      perm_start_q <= 1'b0;
    end else begin
      perm_start_q <= block_end;
      if (perm_load) begin
        state_q <= perm_state_i;
      end else if (in_fire) begin
        state_q[int'(idx_q)*LANE_W +: LANE_W] <= rate_lane ^ absorb_lane;
      end
      if (in_fire | out_fire) begin
        idx_q <= block_end ? '0 : idx_q + IDX_W'(1);
      end
      if (in_fire && in_last) begin
        fin_q <= 1'b1;
      end
    end
  end

  assign state_o    = state_q;
  assign perm_start = perm_start_q;

endmodule
